// File: rtl/idct16_odd_acc.sv
// idct16_odd_acc: serial odd-part accumulator for the 16-point inverse DCT.
// Takes d1,d3,...,d15 one beat at a time and forms O[0..7] with shift-add
// constant products, then presents all eight sums in parallel.
// Optional feature: define IDCT_ODD_SAT_EN to saturate each O[k] to SAT_W
// bits (sign-extended to ACC_W) and report clipping on out_sat.
module idct16_odd_acc #(
   parameter int unsigned IN_W  = 18,
   parameter int unsigned ACC_W = 28,
   parameter int unsigned SAT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_W-1:0]      in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*ACC_W-1:0]   out_data,
   output logic                 out_sat
);

   localparam int unsigned LANES = 8;
   localparam int unsigned CNT_W = 3;

`ifdef IDCT_ODD_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   // Clip limits: -2^(SAT_W-1) and 2^(SAT_W-1)-1 at ACC_W bits.
   localparam logic [ACC_W-1:0] SAT_LO = {{(ACC_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] SAT_HI = {{(ACC_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};

   typedef enum logic {
      S_ACC = 1'b0,
      S_OUT = 1'b1
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [ACC_W-1:0]   acc_q   [LANES];
   logic signed [ACC_W-1:0]   out_q   [LANES];

   logic                      beat;
   logic                      last;
   logic                      take;
   logic signed [ACC_W-1:0]   d_ext;
   logic signed [ACC_W-1:0]   prod    [LANES];
   logic signed [ACC_W-1:0]   term    [LANES];
   logic signed [ACC_W-1:0]   sum     [LANES];
   logic signed [ACC_W-1:0]   lane_out[LANES];
   logic [LANES-1:0]          clip;
   logic [31:0]               row_code;
   logic [3:0]                code;

   assign in_ready = !out_valid;
   assign beat     = in_valid & in_ready;
   assign last     = beat & (cnt_q == CNT_W'(LANES - 1));
   assign take     = out_valid & out_ready;

   // Next-state logic: collect eight beats, then hold the sums until accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACC: if (last) state_d = S_OUT;
         S_OUT: if (take) state_d = S_ACC;
         default: state_d = S_ACC;
      endcase
   end

   // State register and registered out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_ACC;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_d == S_OUT);
      end
   end

   // Coefficient sign/magnitude per lane for the current beat.
   // Nibble k is {negate, magnitude select}; select 0..7 = 9,25,43,57,70,80,87,90.
   always_comb begin
      row_code = 32'h0;
      case (cnt_q)
         3'd0: row_code = 32'h0123_4567;   // C[1]
         3'd1: row_code = 32'h9CFD_A036;   // C[3]
         3'd2: row_code = 32'h2739_EC05;   // C[5]
         3'd3: row_code = 32'hBD17_0EA4;   // C[7]
         3'd4: row_code = 32'h42E8_79D3;   // C[9]
         3'd5: row_code = 32'hD04E_13F2;   // C[11]
         3'd6: row_code = 32'h6B02_D7C1;   // C[13]
         3'd7: row_code = 32'hF6D4_B290;   // C[15]
         default: row_code = 32'h0;
      endcase
   end

   // Shared shift-add magnitudes of the incoming coefficient.
   always_comb begin
      d_ext   = ACC_W'($signed(in_data));
      prod[0] = (d_ext <<< 3) + d_ext;                                     // x9
      prod[1] = (d_ext <<< 4) + (d_ext <<< 3) + d_ext;                     // x25
      prod[2] = (d_ext <<< 5) + (d_ext <<< 3) + (d_ext <<< 1) + d_ext;     // x43
      prod[3] = (d_ext <<< 6) - (d_ext <<< 3) + d_ext;                     // x57
      prod[4] = (d_ext <<< 6) + (d_ext <<< 2) + (d_ext <<< 1);             // x70
      prod[5] = (d_ext <<< 6) + (d_ext <<< 4);                             // x80
      prod[6] = (d_ext <<< 6) + (d_ext <<< 4) + (d_ext <<< 3) - d_ext;     // x87
      prod[7] = (d_ext <<< 6) + (d_ext <<< 4) + (d_ext <<< 3) + (d_ext <<< 1); // x90
   end

   // Per-lane signed term, running sum (beat 0 loads) and optional clipping.
   always_comb begin
      code = 4'h0;
      clip = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         code        = row_code[k*4 +: 4];
         term[k]     = code[3] ? -prod[code[2:0]] : prod[code[2:0]];
         sum[k]      = (cnt_q == '0) ? term[k] : acc_q[k] + term[k];
         clip[k]     = ~((&sum[k][ACC_W-1:SAT_W-1]) | ~(|sum[k][ACC_W-1:SAT_W-1]));
         if (SAT_EN && clip[k])
            lane_out[k] = sum[k][ACC_W-1] ? SAT_LO : SAT_HI;
         else
            lane_out[k] = sum[k];
      end
   end

   // Beat counter and accumulators; a partial column is dropped by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int k = 0; k < int'(LANES); k++) acc_q[k] <= '0;
      end else if (beat) begin
         cnt_q <= cnt_q + CNT_W'(1);
         for (int k = 0; k < int'(LANES); k++) acc_q[k] <= sum[k];
      end
   end

   // Output sums and clip flag, captured on the last beat of a column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sat <= 1'b0;
         for (int k = 0; k < int'(LANES); k++) out_q[k] <= '0;
      end else if (last) begin
         out_sat <= SAT_EN & (|clip);
         for (int k = 0; k < int'(LANES); k++) out_q[k] <= lane_out[k];
      end else if (take) begin
         out_sat <= 1'b0;
      end
   end

   // Pack lane k into bits [k*ACC_W +: ACC_W].
   always_comb begin
      out_data = '0;
      for (int k = 0; k < int'(LANES); k++) out_data[k*ACC_W +: ACC_W] = out_q[k];
   end

endmodule

// File: tb/tb_idct16_odd_acc.sv
// Self-checking bench for idct16_odd_acc: directed columns with a scoreboard
// of reference sums computed by direct multiplication with the C matrix.
module tb_idct16_odd_acc;

   localparam int unsigned IN_W  = 18;
   localparam int unsigned ACC_W = 28;
   localparam int unsigned SAT_W = 16;
   localparam int unsigned OW    = 8 * ACC_W;

   localparam int COEF [8][8] = '{
      '{90,  87,  80,  70,  57,  43,  25,   9},
      '{87,  57,   9, -43, -80, -90, -70, -25},
      '{80,   9, -70, -87, -25,  57,  90,  43},
      '{70, -43, -87,   9,  90,  25, -80, -57},
      '{57, -80, -25,  90,  -9, -87,  43,  70},
      '{43, -90,  57,  25, -87,  70,   9, -80},
      '{25, -70,  90, -80,  43,   9, -57,  87},
      '{ 9, -25,  43, -57,  70, -80,  87, -90}
   };

   typedef struct {
      logic [OW-1:0] data;
      logic          sat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [IN_W-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [OW-1:0]   out_data;
   logic            out_sat;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   idct16_odd_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT_W(SAT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_lane(input string tag, input int k, input int expv);
      logic [ACC_W-1:0] obs;
      logic [ACC_W-1:0] exp;
      obs = out_data[k*ACC_W +: ACC_W];
      exp = ACC_W'(expv);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s lane%0d: observed=%0d expected=%0d", tag, k, $signed(obs), expv);
      end
   endtask

   // Reference: O[k] = sum_n C[2n+1][k]*d[n], optionally clipped to SAT_W bits.
   function automatic exp_t model(input int d[8]);
      exp_t   e;
      longint s;
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (SAT_W - 1)) - 1;
      lo = -(longint'(1) <<< (SAT_W - 1));
      e.data = '0;
      e.sat  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         s = 0;
         for (int n = 0; n < 8; n++) s += longint'(COEF[n][k]) * longint'(d[n]);
`ifdef IDCT_ODD_SAT_EN
         if (s > hi) begin s = hi; e.sat = 1'b1; end
         else if (s < lo) begin s = lo; e.sat = 1'b1; end
`else
         if (s > hi || s < lo) e.sat = 1'b0;
`endif
         e.data[k*ACC_W +: ACC_W] = ACC_W'(s);
      end
      return e;
   endfunction

   task automatic rand_col(output int d[8], input int span);
      for (int n = 0; n < 8; n++) d[n] = int'($urandom_range(0, 2 * span - 1)) - span;
   endtask

   // Drive one column (random idle gaps up to max_gap) and push its expectation.
   task automatic send_column(input int d[8], input int max_gap, input string tag);
      int t;
      int gaps;
      sb.push_back(model(d));
      for (int n = 0; n < 8; n++) begin
         gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gaps) begin
            in_valid = 1'b0;
            in_data  = IN_W'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = IN_W'(d[n]);
         t = 0;
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) chk1({tag, "_beat_timeout"}, in_ready, 1'b1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk1({tag, "_latency"}, out_valid, 1'b1);
   endtask

   // Optionally stall for hold cycles (with in_valid asserted if push_in), then accept.
   task automatic recv_column(input int hold, input bit push_in, input string tag);
      exp_t e;
      int   t;
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) chk1({tag, "_out_timeout"}, out_valid, 1'b1);
      if (sb.size() == 0) begin
         chk1({tag, "_sb_underflow"}, 1'b0, 1'b1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = push_in;
         in_data   = IN_W'($urandom);
         @(negedge clk);
         chk({tag, "_hold_data"}, out_data, e.data);
         chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
         chk1({tag, "_hold_valid"}, out_valid, 1'b1);
      end
      chk({tag, "_data"}, out_data, e.data);
      chk1({tag, "_sat"}, out_sat, e.sat);
      out_ready = 1'b1;
      in_valid  = push_in;
      in_data   = IN_W'($urandom);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk1({tag, "_valid_drop"}, out_valid, 1'b0);
      chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
      chk1({tag, "_sat_clear"}, out_sat, 1'b0);
   endtask

   initial begin
      int d[8];
      int hold;
      bit push;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_sat", out_sat, 1'b0);
      chk("rst_out_data", out_data, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("post_rst_in_ready", in_ready, 1'b1);

      // 1: impulse on d1
      d = '{1, 0, 0, 0, 0, 0, 0, 0};
      send_column(d, 0, "imp1");
      chk_lane("imp1", 0, 90);
      chk_lane("imp1", 3, 70);
      chk_lane("imp1", 7, 9);
      recv_column(0, 1'b0, "imp1");

      // 2: impulse on d15
      d = '{0, 0, 0, 0, 0, 0, 0, 1};
      send_column(d, 0, "imp15");
      chk_lane("imp15", 1, -25);
      chk_lane("imp15", 3, -57);
      chk_lane("imp15", 7, -90);
      recv_column(0, 1'b0, "imp15");

      // 3: full-scale negative input
      d = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072};
      send_column(d, 0, "fullscale");
`ifdef IDCT_ODD_SAT_EN
      chk_lane("fullscale", 0, -32768);
      chk_lane("fullscale", 1, 32767);
      chk1("fullscale_sat_flag", out_sat, 1'b1);
`else
      chk_lane("fullscale", 0, -60424192);
      chk_lane("fullscale", 1, 20316160);
      chk1("fullscale_sat_flag", out_sat, 1'b0);
`endif
      recv_column(0, 1'b0, "fullscale");

      // 4: backpressure with in_valid held high, then immediate next column
      rand_col(d, 300);
      send_column(d, 0, "bp");
      recv_column(5, 1'b1, "bp");
      rand_col(d, 300);
      send_column(d, 0, "bp_next");
      recv_column(0, 1'b0, "bp_next");

      // 5: back-to-back columns with gapped input and random stalls
      for (int c = 0; c < 6; c++) begin
         rand_col(d, (c % 2 == 0) ? 300 : 131072);
         send_column(d, 2, "b2b");
         hold = int'($urandom_range(0, 2));
         push = 1'($urandom_range(0, 1));
         recv_column(hold, push, "b2b");
      end

      // 6: reset mid-column discards the partial sums
      rand_col(d, 131072);
      for (int n = 0; n < 4; n++) begin
         in_valid = 1'b1;
         in_data  = IN_W'(d[n]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      rand_col(d, 300);
      send_column(d, 1, "after_rst");
      recv_column(0, 1'b0, "after_rst");

      chk1("sb_empty", (sb.size() == 0), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
